jtag_dtm: RTL and testbench

JTAG Debug Transport Module: the initiator end of the DMI, per RISC-V Debug Spec 0.13 DTM. It converts JTAG scans arriving on GPIO pins into DMI request/response transactions toward `dm`, which is the DMI responder. TCK is oversampled in the system clock domain, so the block has no second clock. It sits in `top` between `gpio` and `dm`'s DMI port.

---
 rtl/jtag_dtm.sv | 248 ++++++++++++++++++++++++
 tb/tb_jtag_dtm.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dtm.sv
// JTAG Debug Transport Module: oversamples the JTAG pins in the system clock
// domain, runs the IEEE 1149.1 TAP and turns DMI scans into DMI requests.
module jtag_dtm #(
  parameter int unsigned AddressWidth = 7,
  parameter int unsigned DataWidth    = 32,
  parameter logic [31:0] IdCode       = 32'h1000_0001
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tck,
  input  logic                    tms,
  input  logic                    tdi,
  output logic                    tdo,
  output logic                    tdo_en,
  output logic                    dmi_req_valid,
  input  logic                    dmi_req_ready,
  output logic [AddressWidth-1:0] dmi_req_addr,
  output logic [DataWidth-1:0]    dmi_req_data,
  output logic [1:0]              dmi_req_op,
  input  logic                    dmi_rsp_valid,
  output logic                    dmi_rsp_ready,
  input  logic [DataWidth-1:0]    dmi_rsp_data,
  input  logic [1:0]              dmi_rsp_op
);

  localparam int unsigned DrWidth = AddressWidth + DataWidth + 2;
  localparam logic [5:0]  Abits   = 6'(AddressWidth);

  localparam logic [3:0] TLR      = 4'd0;
  localparam logic [3:0] RTI      = 4'd1;
  localparam logic [3:0] SEL_DR   = 4'd2;
  localparam logic [3:0] CAP_DR   = 4'd3;
  localparam logic [3:0] SHIFT_DR = 4'd4;
  localparam logic [3:0] EXIT1_DR = 4'd5;
  localparam logic [3:0] PAUSE_DR = 4'd6;
  localparam logic [3:0] EXIT2_DR = 4'd7;
  localparam logic [3:0] UPD_DR   = 4'd8;
  localparam logic [3:0] SEL_IR   = 4'd9;
  localparam logic [3:0] CAP_IR   = 4'd10;
  localparam logic [3:0] SHIFT_IR = 4'd11;
  localparam logic [3:0] EXIT1_IR = 4'd12;
  localparam logic [3:0] PAUSE_IR = 4'd13;
  localparam logic [3:0] EXIT2_IR = 4'd14;
  localparam logic [3:0] UPD_IR   = 4'd15;

  localparam logic [4:0] IrIdcode = 5'h01;
  localparam logic [4:0] IrDtmcs  = 5'h10;
  localparam logic [4:0] IrDmi    = 5'h11;

  localparam logic [1:0] SelBypass = 2'd0;
  localparam logic [1:0] SelIdcode = 2'd1;
  localparam logic [1:0] SelDtmcs  = 2'd2;
  localparam logic [1:0] SelDmi    = 2'd3;

  logic [1:0]              tck_sync, tms_sync, tdi_sync;
  logic                    tck_q;
  logic                    rise, fall, tms_s, tdi_s;
  logic [3:0]              tap, tap_next;
  logic [4:0]              ir, ir_shift;
  logic [DrWidth-1:0]      dr_shift, dr_shifted, dr_cap;
  logic [1:0]              dr_sel;
  logic [1:0]              sticky, dmi_cap_op;
  logic                    busy, drain;
  logic [AddressWidth-1:0] last_addr;
  logic [DataWidth-1:0]    last_data;
  logic                    dmi_capture, dmi_update, dtmcs_update, hard_now;
  logic                    rsp_hs, rsp_take;
  logic [1:0]              upd_op;

  // Two-flop synchronizers plus a TCK history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_q    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], tck};
      tms_sync <= {tms_sync[0], tms};
      tdi_sync <= {tdi_sync[0], tdi};
      tck_q    <= tck_sync[1];
    end
  end

  assign rise  = tck_sync[1] & ~tck_q;
  assign fall  = ~tck_sync[1] & tck_q;
  assign tms_s = tms_sync[1];
  assign tdi_s = tdi_sync[1];

  // TAP next-state function
  always_comb begin
    tap_next = TLR;
    case (tap)
      TLR:      tap_next = tms_s ? TLR      : RTI;
      RTI:      tap_next = tms_s ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: tap_next = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: tap_next = tms_s ? UPD_DR   : SHIFT_DR;
      UPD_DR:   tap_next = tms_s ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms_s ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: tap_next = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: tap_next = tms_s ? UPD_IR   : SHIFT_IR;
      UPD_IR:   tap_next = tms_s ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
  end

  // DR selection, capture values and the one-bit shift of the selected DR
  always_comb begin
    case (ir)
      IrIdcode: dr_sel = SelIdcode;
      IrDtmcs:  dr_sel = SelDtmcs;
      IrDmi:    dr_sel = SelDmi;
      default:  dr_sel = SelBypass;
    endcase

    if (sticky != 2'd0)
      dmi_cap_op = sticky;
    else if (busy)
      dmi_cap_op = 2'd3;
    else
      dmi_cap_op = 2'd0;

    case (dr_sel)
      SelIdcode: dr_cap = DrWidth'(IdCode);
      SelDtmcs:  dr_cap = DrWidth'({17'b0, 3'd1, sticky, Abits, 4'd1});
      SelDmi:    dr_cap = {last_addr, last_data, dmi_cap_op};
      default:   dr_cap = '0;
    endcase

    // tdi enters the MSB of the active register length
    dr_shifted = dr_shift >> 1;
    case (dr_sel)
      SelIdcode, SelDtmcs: dr_shifted[31] = tdi_s;
      SelDmi:              dr_shifted[DrWidth-1] = tdi_s;
      default: begin
        dr_shifted    = '0;
        dr_shifted[0] = tdi_s;
      end
    endcase
  end

  // TAP state, IR and DR shift paths; tdo/tdo_en move on falling events only
  always_ff @(posedge clk) begin
    if (rst) begin
      tap      <= TLR;
      ir       <= IrIdcode;
      ir_shift <= '0;
      dr_shift <= '0;
      tdo      <= 1'b0;
      tdo_en   <= 1'b0;
    end else begin
      if (tap == TLR)
        ir <= IrIdcode;
      if (rise) begin
        tap <= tap_next;
        case (tap)
          CAP_IR:   ir_shift <= 5'b00001;
          SHIFT_IR: ir_shift <= {tdi_s, ir_shift[4:1]};
          UPD_IR:   ir       <= ir_shift;
          CAP_DR:   dr_shift <= dr_cap;
          SHIFT_DR: dr_shift <= dr_shifted;
          default:  ;
        endcase
      end
      if (fall) begin
        tdo_en <= (tap == SHIFT_IR) || (tap == SHIFT_DR);
        tdo    <= (tap == SHIFT_IR) ? ir_shift[0] : dr_shift[0];
      end
    end
  end

  assign upd_op       = dr_shift[1:0];
  assign dmi_capture  = rise && (tap == CAP_DR) && (ir == IrDmi);
  assign dmi_update   = rise && (tap == UPD_DR) && (ir == IrDmi) &&
                        ((upd_op == 2'd1) || (upd_op == 2'd2));
  assign dtmcs_update = rise && (tap == UPD_DR) && (ir == IrDtmcs);
  assign hard_now     = dtmcs_update && dr_shift[17];
  assign rsp_hs       = dmi_rsp_valid && dmi_rsp_ready;
  assign rsp_take     = rsp_hs && !hard_now;

  // drain keeps accepting the response of a request abandoned after dm took it
  assign dmi_rsp_ready = (busy | drain) & ~dmi_req_valid;

  // DMI request/response bookkeeping; later statements take priority
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky        <= '0;
      busy          <= 1'b0;
      drain         <= 1'b0;
      last_addr     <= '0;
      last_data     <= '0;
      dmi_req_valid <= 1'b0;
      dmi_req_addr  <= '0;
      dmi_req_data  <= '0;
      dmi_req_op    <= '0;
    end else begin
      if (dmi_req_valid && dmi_req_ready)
        dmi_req_valid <= 1'b0;

      if (rsp_take) begin
        if (drain) begin
          drain <= 1'b0;
        end else begin
          last_data <= dmi_rsp_data;
          busy      <= 1'b0;
          if ((dmi_rsp_op == 2'd2) && (sticky == 2'd0))
            sticky <= 2'd2;
        end
      end

      if (dmi_capture && (sticky == 2'd0) && busy)
        sticky <= 2'd3;

      if (dmi_update) begin
        if (busy) begin
          sticky <= 2'd3;
        end else if ((sticky == 2'd0) && !drain) begin
          dmi_req_valid <= 1'b1;
          dmi_req_addr  <= dr_shift[DrWidth-1:DataWidth+2];
          dmi_req_data  <= dr_shift[DataWidth+1:2];
          dmi_req_op    <= upd_op;
          last_addr     <= dr_shift[DrWidth-1:DataWidth+2];
          busy          <= 1'b1;
        end
      end

      if (dtmcs_update && dr_shift[16])
        sticky <= 2'd0;

      // A request dm already accepted still owes a response; drain absorbs it
      // unless that response is being handed over in this very cycle.
      if (hard_now) begin
        sticky        <= 2'd0;
        busy          <= 1'b0;
        dmi_req_valid <= 1'b0;
        drain         <= (drain || (busy && (!dmi_req_valid || dmi_req_ready))) && !rsp_hs;
      end
    end
  end

endmodule

// File: tb/tb_jtag_dtm.sv
// Self-checking bench for jtag_dtm: bit-banged JTAG scans, a DMI responder
// and a transaction-level model of the DTM's DMI state.
module tb_jtag_dtm;

  localparam int DrLen = 41;

  logic        clk = 1'b0;
  logic        rst, tck, tms, tdi;
  logic        tdo, tdo_en;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_rsp_valid, dmi_rsp_ready;
  logic [31:0] dmi_rsp_data;
  logic [1:0]  dmi_rsp_op;

  jtag_dtm #(.AddressWidth(7), .DataWidth(32), .IdCode(32'h1000_0001)) dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // responder environment
  bit          ready_en = 1'b1;
  bit          rsp_hold = 1'b0;
  int          hs_count = 0;
  int          rsp_count = 0;
  logic [6:0]  hs_addr;
  logic [31:0] hs_data;
  logic [1:0]  hs_op;
  logic [31:0] dm_mem [128];
  bit          hs_now, rsp_now, rst_now, rsp_pend;
  logic [6:0]  ha, pend_a;
  logic [31:0] hd;
  logic [1:0]  ho, pend_op;
  int          rdy_cnt, rsp_cnt;

  // model of the DTM's DMI-side state
  logic [1:0]  m_sticky;
  bit          m_busy;
  logic [6:0]  m_last_addr, m_pend_addr;
  logic [31:0] m_last_data, m_pend_data;
  logic [1:0]  m_pend_op;
  logic [31:0] m_mem [128];

  function automatic logic [31:0] mem_init(input int i);
    if (i == 'h11) return 32'hDEAD_BEEF;
    return {8'hA5, 8'(i), 16'(i * 977 + 3)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // dm side: accepts a request after a few cycles, answers two cycles later;
  // reads return memory contents, writes return 0, address 0x7F reports failure
  initial begin
    dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_data = '0; dmi_rsp_op = '0;
    rdy_cnt = 0; rsp_cnt = 0; rsp_pend = 1'b0;
    for (int i = 0; i < 128; i++) dm_mem[i] = mem_init(i);
    forever begin
      @(negedge clk);
      rst_now = rst;
      hs_now  = dmi_req_valid && dmi_req_ready;
      rsp_now = dmi_rsp_valid && dmi_rsp_ready;
      ha = dmi_req_addr; hd = dmi_req_data; ho = dmi_req_op;
      @(posedge clk); #1;
      if (rst_now) begin
        dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; rsp_pend = 1'b0; rdy_cnt = 0; rsp_cnt = 0;
      end else begin
        if (rsp_now) begin
          dmi_rsp_valid = 1'b0;
          rsp_count++;
        end
        if (hs_now) begin
          hs_count++;
          hs_addr = ha; hs_data = hd; hs_op = ho;
          if (ho == 2'd2) dm_mem[ha] = hd;
          dmi_req_ready = 1'b0; rdy_cnt = 0;
          rsp_pend = 1'b1; rsp_cnt = 0; pend_a = ha; pend_op = ho;
        end else if (dmi_req_valid && ready_en) begin
          if (rdy_cnt >= 3) dmi_req_ready = 1'b1;
          else rdy_cnt++;
        end else begin
          dmi_req_ready = 1'b0; rdy_cnt = 0;
        end
        if (rsp_pend && !rsp_hold && !dmi_rsp_valid) begin
          if (rsp_cnt >= 2) begin
            dmi_rsp_valid = 1'b1;
            dmi_rsp_data  = (pend_op == 2'd1) ? dm_mem[pend_a] : 32'h0;
            dmi_rsp_op    = (pend_a == 7'h7F) ? 2'd2 : 2'd0;
            rsp_pend      = 1'b0;
          end else begin
            rsp_cnt++;
          end
        end
      end
    end
  end

  task automatic model_reset();
    m_sticky = '0; m_busy = 1'b0; m_last_addr = '0; m_last_data = '0;
  endtask

  task automatic model_capture(output logic [6:0] ea, output logic [31:0] ed, output logic [1:0] eo);
    ea = m_last_addr;
    ed = m_last_data;
    if (m_sticky != 2'd0) eo = m_sticky;
    else if (m_busy) begin eo = 2'd3; m_sticky = 2'd3; end
    else eo = 2'd0;
  endtask

  task automatic model_update(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                              output bit issued);
    issued = 1'b0;
    if (op == 2'd1 || op == 2'd2) begin
      if (m_busy) m_sticky = 2'd3;
      else if (m_sticky == 2'd0) begin
        m_busy = 1'b1; m_last_addr = a;
        m_pend_addr = a; m_pend_data = d; m_pend_op = op;
        issued = 1'b1;
      end
    end
  endtask

  task automatic model_response();
    m_busy = 1'b0;
    if (m_pend_op == 2'd2) begin
      m_mem[m_pend_addr] = m_pend_data;
      m_last_data = 32'h0;
    end else begin
      m_last_data = m_mem[m_pend_addr];
    end
    if (m_pend_addr == 7'h7F && m_sticky == 2'd0) m_sticky = 2'd2;
  endtask

  task automatic wait_cnt(input string tag, input int target, input bit use_rsp);
    int n = 0;
    while (((use_rsp ? rsp_count : hs_count) < target) && n < 400) begin
      @(posedge clk);
      n++;
    end
    check(tag, 64'((use_rsp ? rsp_count : hs_count) >= target), 64'd1);
  endtask

  // one TCK period; tdo is sampled before the rising edge
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    @(posedge clk); #1;
    tdo_v = tdo;
    tms = tms_v; tdi = tdi_v;
    repeat (2) @(posedge clk);
    #1 tck = 1'b1;
    repeat (6) @(posedge clk);
    #1 tck = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic set_ir(input logic [4:0] v);
    logic b;
    logic [4:0] cap;
    tck_cycle(1, 0, b); tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, v[i], b);
      cap[i] = b;
    end
    tck_cycle(1, 0, b); tck_cycle(0, 0, b);
    check("ir_capture", 64'(cap), 64'h01);
  endtask

  task automatic shift_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
    for (int i = 0; i < len; i++) begin
      if (i == 0) check("tdo_en_shift", 64'(tdo_en), 64'd1);
      tck_cycle(i == len - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1, 0, b); tck_cycle(0, 0, b);
    check("tdo_en_idle", 64'(tdo_en), 64'd0);
  endtask

  task automatic dtmcs_scan(input logic [31:0] w);
    logic [63:0] o;
    shift_dr(32, 64'(w), o);
    check("dtmcs", o, 64'({17'b0, 3'd1, m_sticky, 6'd7, 4'd1}));
    if (w[16] || w[17]) m_sticky = 2'd0;
    if (w[17]) m_busy = 1'b0;
  endtask

  task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                          input bit complete);
    logic [63:0] o;
    logic [6:0]  ea;
    logic [31:0] ed;
    logic [1:0]  eo;
    bit          issued;
    int          h0, r0;
    h0 = hs_count; r0 = rsp_count;
    model_capture(ea, ed, eo);
    shift_dr(DrLen, {23'b0, a, d, op}, o);
    check("dmi_cap_op", 64'(o[1:0]), 64'(eo));
    check("dmi_cap_data", 64'(o[33:2]), 64'(ed));
    check("dmi_cap_addr", 64'(o[40:34]), 64'(ea));
    model_update(a, d, op, issued);
    if (issued && complete) begin
      wait_cnt("req_handshake_timeout", h0 + 1, 1'b0);
      check("req_addr", 64'(hs_addr), 64'(a));
      check("req_data", 64'(hs_data), 64'(d));
      check("req_op", 64'(hs_op), 64'(op));
      wait_cnt("rsp_handshake_timeout", r0 + 1, 1'b1);
      model_response();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tdo"}, 64'(tdo), 64'd0);
    check({tag, "_tdo_en"}, 64'(tdo_en), 64'd0);
    check({tag, "_req_valid"}, 64'(dmi_req_valid), 64'd0);
    check({tag, "_rsp_ready"}, 64'(dmi_rsp_ready), 64'd0);
    check({tag, "_req_payload"}, {dmi_req_addr, dmi_req_data, dmi_req_op}, 64'd0);
  endtask

  initial begin
    logic [63:0] o;
    logic [7:0]  pat;
    logic        b;
    int          h0, r0;
    logic [6:0]  ra;

    for (int i = 0; i < 128; i++) m_mem[i] = mem_init(i);
    model_reset();
    rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;

    // IDCODE after reset
    for (int i = 0; i < 5; i++) tck_cycle(1, 0, b);
    tck_cycle(0, 0, b);
    shift_dr(32, 64'h0, o);
    check("idcode", o, 64'h1000_0001);

    // BYPASS: one-bit register capturing 0
    pat = 8'($urandom);
    set_ir(5'h1F);
    shift_dr(8, 64'(pat), o);
    check("bypass", o, 64'({pat[6:0], 1'b0}));

    // DTMCS read
    set_ir(5'h10);
    dtmcs_scan(32'h0);

    // DMI write, then read of 0xDEADBEEF
    set_ir(5'h11);
    h0 = hs_count;
    dmi_scan(7'h10, 32'h0000_0001, 2'd2, 1'b1);
    repeat (30) @(posedge clk);
    check("write_single_handshake", 64'(hs_count - h0), 64'd1);
    dmi_scan(7'h11, 32'h0, 2'd1, 1'b1);
    dmi_scan(7'h00, 32'h0, 2'd0, 1'b1);

    // randomized transactions
    for (int i = 0; i < 10; i++) begin
      ra = 7'($urandom_range(0, 126));
      dmi_scan(ra, $urandom, 2'($urandom_range(1, 2)), 1'b1);
    end
    dmi_scan(7'h00, 32'h0, 2'd0, 1'b1);

    // busy and sticky
    ready_en = 1'b0;
    dmi_scan(7'h22, 32'h0, 2'd1, 1'b0);
    dmi_scan(7'h00, 32'h0, 2'd0, 1'b0);
    h0 = hs_count;
    dmi_scan(7'h30, 32'h1234_5678, 2'd2, 1'b0);
    check("busy_req_held_valid", 64'(dmi_req_valid), 64'd1);
    check("busy_req_held_addr", 64'(dmi_req_addr), 64'h22);
    check("busy_req_held_op", 64'(dmi_req_op), 64'd1);
    check("busy_no_new_handshake", 64'(hs_count), 64'(h0));
    set_ir(5'h10);
    dtmcs_scan(32'h0);
    dtmcs_scan(32'h0001_0000);
    dtmcs_scan(32'h0);
    r0 = rsp_count;
    ready_en = 1'b1;
    wait_cnt("busy_release_handshake", h0 + 1, 1'b0);
    check("busy_release_addr", 64'(hs_addr), 64'h22);
    wait_cnt("busy_release_rsp", r0 + 1, 1'b1);
    model_response();
    set_ir(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, 1'b1);

    // failed response sets sticky 2
    dmi_scan(7'h7F, 32'h0, 2'd1, 1'b1);
    dmi_scan(7'h05, 32'h0, 2'd1, 1'b1);
    set_ir(5'h10);
    dtmcs_scan(32'h0001_0000);
    dtmcs_scan(32'h0);

    // dmihardreset while the request is still pending
    set_ir(5'h11);
    ready_en = 1'b0;
    dmi_scan(7'h33, 32'hCAFE_0000, 2'd2, 1'b0);
    check("hr_req_pending", 64'(dmi_req_valid), 64'd1);
    h0 = hs_count;
    set_ir(5'h10);
    dtmcs_scan(32'h0002_0000);
    repeat (5) @(posedge clk);
    #1 check("hr_req_dropped", 64'(dmi_req_valid), 64'd0);
    check("hr_rsp_ready_low", 64'(dmi_rsp_ready), 64'd0);
    ready_en = 1'b1;
    repeat (20) @(posedge clk);
    check("hr_no_handshake", 64'(hs_count), 64'(h0));
    set_ir(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, 1'b1);

    // dmihardreset after dm accepted; the late response is discarded
    rsp_hold = 1'b1;
    h0 = hs_count;
    dmi_scan(7'h44, 32'h0, 2'd1, 1'b0);
    wait_cnt("hr2_handshake", h0 + 1, 1'b0);
    set_ir(5'h10);
    dtmcs_scan(32'h0002_0000);
    r0 = rsp_count;
    rsp_hold = 1'b0;
    wait_cnt("hr2_late_rsp_consumed", r0 + 1, 1'b1);
    set_ir(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, 1'b1);
    dmi_scan(7'h45, 32'h0, 2'd1, 1'b1);
    dmi_scan(7'h00, 32'h0, 2'd0, 1'b1);

    // TLR keeps DMI state; IR returns to IDCODE
    for (int i = 0; i < 5; i++) tck_cycle(1, 0, b);
    tck_cycle(0, 0, b);
    shift_dr(32, 64'h0, o);
    check("idcode_after_tlr", o, 64'h1000_0001);
    set_ir(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, 1'b1);

    // rst with a request pending
    ready_en = 1'b0;
    dmi_scan(7'h50, 32'h0000_0077, 2'd2, 1'b0);
    check("rst_req_pending", 64'(dmi_req_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 check_reset_outputs("midrst");
    rst = 1'b0;
    model_reset();
    ready_en = 1'b1;
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
